// File: rtl/cext_align_pkg.sv
// Shared types and constants for the RVC aligner/expander.
// State encoding is kept as plain logic constants for legacy compatibility.
package cext_align_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [0:0] type_cext_state_e;
    localparam type_cext_state_e CEXT_IDLE  = 1'b0;
    localparam type_cext_state_e CEXT_SPLIT = 1'b1;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_C_ADDI4SPN = 3'b000;
    localparam logic [2:0] F3_C_LW       = 3'b010;
    localparam logic [2:0] F3_C_SW       = 3'b110;
    localparam logic [2:0] F3_C_ADDI     = 3'b000;
    localparam logic [2:0] F3_C_JAL      = 3'b001;
    localparam logic [2:0] F3_C_LI       = 3'b010;
    localparam logic [2:0] F3_C_LUI      = 3'b011;
    localparam logic [2:0] F3_C_MISC_ALU = 3'b100;
    localparam logic [2:0] F3_C_J        = 3'b101;
    localparam logic [2:0] F3_C_BEQZ     = 3'b110;
    localparam logic [2:0] F3_C_BNEZ     = 3'b111;
    localparam logic [2:0] F3_C_SLLI     = 3'b000;
    localparam logic [2:0] F3_C_LWSP     = 3'b010;
    localparam logic [2:0] F3_C_JR_MV    = 3'b100;
    localparam logic [2:0] F3_C_SWSP     = 3'b110;

    typedef struct packed {
        logic            is_comp;
        logic [XLEN-1:0] pc_aligned;
        logic            stall;
    } type_cext2if_s;

    typedef struct packed {
        logic [XLEN-1:0] pc_ff;
        logic            icache_valid;
    } type_if2cext_s;

endpackage

// File: rtl/cext_decompress.sv
// Combinational RV32C expander: one 16-bit parcel to its 32-bit equivalent,
// with a flag for reserved or non-RV32 encodings.
module cext_decompress
    import cext_align_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    logic [15:0] c;
    logic [4:0]  rd, rs2, rdp, rs1p;

    assign c    = instr_i;
    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[4:2]};
    assign rs1p = {2'b01, c[9:7]};

    always_comb begin
        instr_o   = INSTR_NOP;
        illegal_o = 1'b0;
        case (c[1:0])
            RVC_Q0: begin
                case (c[15:13])
                    F3_C_ADDI4SPN: begin
                        instr_o   = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000,
                                     rdp, OPC_OP_IMM};
                        illegal_o = (c[12:5] == 8'h00);
                    end
                    F3_C_LW: instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp,
                                        OPC_LOAD};
                    F3_C_SW: instr_o = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6],
                                        2'b00, OPC_STORE};
                    default: illegal_o = 1'b1;
                endcase
            end
            RVC_Q1: begin
                case (c[15:13])
                    F3_C_ADDI: instr_o = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OPC_OP_IMM};
                    F3_C_JAL, F3_C_J: begin
                        // c.jal links x1, c.j links x0; funct3[2] tells them apart
                        instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                                   {8{c[12]}}, 4'b0000, ~c[15], OPC_JAL};
                    end
                    F3_C_LI: instr_o = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
                    F3_C_LUI: begin
                        if (rd == 5'd2) begin
                            instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2,
                                       3'b000, 5'd2, OPC_OP_IMM};
                        end else begin
                            instr_o = {{15{c[12]}}, c[6:2], rd, OPC_LUI};
                        end
                        illegal_o = ({c[12], c[6:2]} == 6'd0);
                    end
                    F3_C_MISC_ALU: begin
                        case (c[11:10])
                            2'b00: begin
                                instr_o   = {7'b0, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                                illegal_o = c[12];
                            end
                            2'b01: begin
                                instr_o   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                                illegal_o = c[12];
                            end
                            2'b10: instr_o = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OPC_OP_IMM};
                            default: begin
                                illegal_o = c[12];
                                case (c[6:5])
                                    2'b00: instr_o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                                    2'b01: instr_o = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                                    2'b10: instr_o = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                                    default: instr_o = {7'b0, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    default: begin
                        instr_o = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13],
                                   c[11:10], c[4:3], c[12], OPC_BRANCH};
                    end
                endcase
            end
            RVC_Q2: begin
                case (c[15:13])
                    F3_C_SLLI: begin
                        instr_o   = {7'b0, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
                        illegal_o = c[12];
                    end
                    F3_C_LWSP: begin
                        instr_o   = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd,
                                     OPC_LOAD};
                        illegal_o = (rd == 5'd0);
                    end
                    F3_C_JR_MV: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                instr_o   = {12'b0, rd, 3'b000, 5'd0, OPC_JALR};
                                illegal_o = (rd == 5'd0);
                            end else begin
                                instr_o = {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP};
                            end
                        end else if (rs2 == 5'd0) begin
                            instr_o = (rd == 5'd0) ? 32'h0010_0073
                                                   : {12'b0, rd, 3'b000, 5'd1, OPC_JALR};
                        end else begin
                            instr_o = {7'b0, rs2, rd, 3'b000, rd, OPC_OP};
                        end
                    end
                    F3_C_SWSP: instr_o = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9],
                                          2'b00, OPC_STORE};
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cext_align.sv
// Instruction aligner between icache and decode; expands RVC and stitches straddling
// 32-bit instructions. Compressed support is built only when C_EXT_EN is defined.
module cext_align
    import cext_align_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    input  logic            icache_ack_i,
    input  logic [31:0]     icache_rdata_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] icache_addr_o,
    output logic [31:0]     instr_o,
    output logic            is_comp_o,
    output logic [XLEN-1:0] pc_aligned_o,
    output logic            instr_valid_o,
    output logic            stall_o,
    output logic            illegal_o
);

    type_cext2if_s cext2if;

    assign is_comp_o    = cext2if.is_comp;
    assign pc_aligned_o = cext2if.pc_aligned;
    assign stall_o      = cext2if.stall;

`ifdef C_EXT_EN
    type_cext_state_e state_q, state_d;
    logic [15:0]      lo_buf_q, lo_buf_d;
    logic [15:0]      hw;
    logic [31:0]      exp_instr;
    logic             exp_illegal;

    assign hw = pc_i[1] ? icache_rdata_i[31:16] : icache_rdata_i[15:0];

    cext_decompress u_decompress (
        .instr_i   (hw),
        .instr_o   (exp_instr),
        .illegal_o (exp_illegal)
    );

    // Second half of a straddle lives in the next word; pc_i is held meanwhile.
    assign icache_addr_o = (state_q == CEXT_SPLIT) ? {pc_i[31:2] + 30'd1, 2'b00}
                                                   : {pc_i[31:2], 2'b00};

    always_comb begin
        state_d            = state_q;
        lo_buf_d           = lo_buf_q;
        instr_o            = INSTR_NOP;
        instr_valid_o      = 1'b0;
        illegal_o          = 1'b0;
        cext2if.is_comp    = 1'b0;
        cext2if.pc_aligned = pc_i;
        cext2if.stall      = 1'b0;
        if (flush_i) begin
            state_d  = CEXT_IDLE;
            lo_buf_d = '0;
        end else if (state_q == CEXT_SPLIT) begin
            if (icache_ack_i) begin
                instr_o       = {icache_rdata_i[15:0], lo_buf_q};
                instr_valid_o = 1'b1;
                state_d       = CEXT_IDLE;
            end else begin
                cext2if.stall = 1'b1;
            end
        end else if (icache_ack_i) begin
            if (hw[1:0] != 2'b11) begin
                instr_o         = exp_illegal ? {16'h0000, hw} : exp_instr;
                illegal_o       = exp_illegal;
                cext2if.is_comp = 1'b1;
                instr_valid_o   = 1'b1;
            end else if (!pc_i[1]) begin
                instr_o       = icache_rdata_i;
                instr_valid_o = 1'b1;
            end else begin
                lo_buf_d      = hw;
                state_d       = CEXT_SPLIT;
                cext2if.stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CEXT_IDLE;
            lo_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_buf_q <= lo_buf_d;
        end
    end
`else
    logic unused_sigs;

    assign unused_sigs   = ^{clk, rst_n, flush_i, pc_i[1:0]};
    assign icache_addr_o = {pc_i[31:2], 2'b00};
    assign instr_o       = icache_ack_i ? icache_rdata_i : INSTR_NOP;
    assign instr_valid_o = icache_ack_i;
    assign illegal_o     = 1'b0;

    always_comb begin
        cext2if.is_comp    = 1'b0;
        cext2if.pc_aligned = pc_i;
        cext2if.stall      = 1'b0;
    end
`endif

endmodule

// File: tb/tb_cext_align.sv
// Directed and random bench for cext_align against an ISA-level reference model.
module tb_cext_align;

`ifdef C_EXT_EN
    localparam bit CEXT = 1'b1;
`else
    localparam bit CEXT = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i, icache_rdata_i, icache_addr_o, instr_o, pc_aligned_o;
    logic        icache_ack_i, flush_i, is_comp_o, instr_valid_o, stall_o, illegal_o;

    int errors = 0;
    int checks = 0;

    // Reference model state: a straddle is pending and its saved low half
    logic        m_split, n_split;
    logic [15:0] m_lo, n_lo;

    cext_align dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_i           (pc_i),
        .icache_ack_i   (icache_ack_i),
        .icache_rdata_i (icache_rdata_i),
        .flush_i        (flush_i),
        .icache_addr_o  (icache_addr_o),
        .instr_o        (instr_o),
        .is_comp_o      (is_comp_o),
        .pc_aligned_o   (pc_aligned_o),
        .instr_valid_o  (instr_valid_o),
        .stall_o        (stall_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    // RV32C expansion from the ISA tables: decode fields, then re-encode with base formats
    task automatic model_expand(input logic [15:0] c, output logic [31:0] ins, output logic ill);
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [31:0] ci, jimm, bimm, imm;
        logic [2:0]  alu_f3 [4];
        alu_f3 = '{3'd0, 3'd4, 3'd6, 3'd7};
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = 5'd8 + {2'b00, c[4:2]};
        rs1p = 5'd8 + {2'b00, c[9:7]};
        ci   = {{26{c[12]}}, c[12], c[6:2]};
        jimm = {{20{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        bimm = {{23{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        ill  = 1'b0;
        ins  = '0;
        case ({c[15:13], c[1:0]})
            5'b000_00: begin
                imm = {22'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
                ill = (imm == '0);
                ins = enc_i(imm, 5'd2, 3'd0, rdp, 7'h13);
            end
            5'b010_00: ins = enc_i({25'b0, c[5], c[12:10], c[6], 2'b00}, rs1p, 3'd2, rdp, 7'h03);
            5'b110_00: ins = enc_s({25'b0, c[5], c[12:10], c[6], 2'b00}, rdp, rs1p, 3'd2);
            5'b000_01: ins = enc_i(ci, rd, 3'd0, rd, 7'h13);
            5'b001_01: ins = enc_j(jimm, 5'd1);
            5'b101_01: ins = enc_j(jimm, 5'd0);
            5'b010_01: ins = enc_i(ci, 5'd0, 3'd0, rd, 7'h13);
            5'b011_01: begin
                ill = (ci == '0);
                if (rd == 5'd2) begin
                    imm = {{22{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0};
                    ins = enc_i(imm, 5'd2, 3'd0, 5'd2, 7'h13);
                end else begin
                    imm = ci << 12;
                    ins = {imm[31:12], rd, 7'h37};
                end
            end
            5'b100_01: begin
                case (c[11:10])
                    2'd0: begin ill = c[12]; ins = enc_i({27'b0, c[6:2]}, rs1p, 3'd5, rs1p, 7'h13); end
                    2'd1: begin ill = c[12]; ins = enc_i({20'b0, 7'h20, c[6:2]}, rs1p, 3'd5, rs1p, 7'h13); end
                    2'd2: ins = enc_i(ci, rs1p, 3'd7, rs1p, 7'h13);
                    default: begin
                        ill = c[12];
                        ins = enc_r((c[6:5] == 2'd0) ? 7'h20 : 7'h00, rdp, rs1p, alu_f3[c[6:5]], rs1p);
                    end
                endcase
            end
            5'b110_01: ins = enc_b(bimm, rs1p, 3'd0);
            5'b111_01: ins = enc_b(bimm, rs1p, 3'd1);
            5'b000_10: begin ill = c[12]; ins = enc_i({27'b0, c[6:2]}, rd, 3'd1, rd, 7'h13); end
            5'b010_10: begin
                ill = (rd == 5'd0);
                ins = enc_i({24'b0, c[3:2], c[12], c[6:4], 2'b00}, 5'd2, 3'd2, rd, 7'h03);
            end
            5'b100_10: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0) begin
                        ill = (rd == 5'd0);
                        ins = enc_i(32'd0, rd, 3'd0, 5'd0, 7'h67);
                    end else ins = enc_r(7'h00, rs2, 5'd0, 3'd0, rd);
                end else if (rs2 == 5'd0) begin
                    ins = (rd == 5'd0) ? 32'h0010_0073 : enc_i(32'd0, rd, 3'd0, 5'd1, 7'h67);
                end else ins = enc_r(7'h00, rs2, rd, 3'd0, rd);
            end
            5'b110_10: ins = enc_s({24'b0, c[8:7], c[12:9], 2'b00}, rs2, 5'd2, 3'd2);
            default: ill = 1'b1;
        endcase
    endtask

    task automatic check_model();
        logic [31:0] e_instr, e_addr;
        logic        e_valid, e_stall, e_ill, e_comp, do_instr, do_comp;
        e_instr = NOP;
        e_valid = 1'b0;
        e_stall = 1'b0;
        e_ill = 1'b0;
        e_comp = 1'b0;
        do_instr = 1'b1;
        do_comp = 1'b1;
        n_split = m_split;
        n_lo = m_lo;
`ifdef C_EXT_EN
        begin
            logic [15:0] hw;
            logic [31:0] x;
            logic        xi;
            hw = pc_i[1] ? icache_rdata_i[31:16] : icache_rdata_i[15:0];
            e_addr = m_split ? (pc_i & 32'hFFFF_FFFC) + 32'd4 : (pc_i & 32'hFFFF_FFFC);
            if (flush_i) begin
                do_instr = 1'b0; do_comp = 1'b0; n_split = 1'b0; n_lo = '0;
            end else if (m_split) begin
                if (icache_ack_i) begin
                    e_instr = {icache_rdata_i[15:0], m_lo}; e_valid = 1'b1; n_split = 1'b0;
                end else begin
                    e_stall = 1'b1; do_instr = 1'b0; do_comp = 1'b0;
                end
            end else if (icache_ack_i) begin
                if (hw[1:0] != 2'b11) begin
                    model_expand(hw, x, xi);
                    e_comp = 1'b1; e_valid = 1'b1; e_ill = xi;
                    e_instr = xi ? {16'h0000, hw} : x;
                end else if (!pc_i[1]) begin
                    e_instr = icache_rdata_i; e_valid = 1'b1;
                end else begin
                    e_stall = 1'b1; do_instr = 1'b0; do_comp = 1'b0; n_split = 1'b1; n_lo = hw;
                end
            end
        end
`else
        e_addr = pc_i & 32'hFFFF_FFFC;
        if (icache_ack_i) begin
            e_instr = icache_rdata_i;
            e_valid = 1'b1;
        end
`endif
        chk1("valid", instr_valid_o, e_valid);
        chk1("stall", stall_o, e_stall);
        chk1("illegal", illegal_o, e_ill);
        chk("addr", icache_addr_o, e_addr);
        chk("pc_aligned", pc_aligned_o, pc_i);
        if (do_instr) chk("instr", instr_o, e_instr);
        if (do_comp) chk1("is_comp", is_comp_o, e_comp);
    endtask

    task automatic drive(input logic [31:0] p, input logic a, input logic [31:0] d,
                         input logic f);
        pc_i = p;
        icache_ack_i = a;
        icache_rdata_i = d;
        flush_i = f;
        #3;
    endtask

    task automatic advance();
        @(posedge clk);
        m_split = n_split;
        m_lo = n_lo;
        #1;
    endtask

    initial begin
        logic [31:0] pc, data;
        rst_n = 1'b0;
        m_split = 1'b0;
        m_lo = '0;
        drive(32'h8000_0000, 1'b0, 32'h0, 1'b0);
        check_model();
        chk("rst_instr", instr_o, NOP);
        chk1("rst_valid", instr_valid_o, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(32'h8000_0000, 1'b1, 32'h0050_0093, 1'b0);
        check_model();
        chk("aligned_instr", instr_o, 32'h0050_0093);
        chk1("aligned_comp", is_comp_o, 1'b0);
        advance();

        drive(32'h8000_0000, 1'b1, 32'h0001_4095, 1'b0);
        check_model();
        chk("clo_instr", instr_o, CEXT ? 32'h0050_0093 : 32'h0001_4095);
        chk1("clo_comp", is_comp_o, CEXT);
        advance();

        drive(32'h8000_0002, 1'b1, 32'h4095_0001, 1'b0);
        check_model();
        chk("chi_instr", instr_o, CEXT ? 32'h0050_0093 : 32'h4095_0001);
        chk("chi_pc", pc_aligned_o, 32'h8000_0002);
        advance();

        drive(32'h8000_0006, 1'b1, 32'h0093_ABCD, 1'b0);
        check_model();
        chk1("st1_stall", stall_o, CEXT);
        advance();
        drive(32'h8000_0006, 1'b1, 32'h1234_0050, 1'b0);
        check_model();
        chk("st2_addr", icache_addr_o, CEXT ? 32'h8000_0008 : 32'h8000_0004);
        chk("st2_instr", instr_o, CEXT ? 32'h0050_0093 : 32'h1234_0050);
        advance();

        drive(32'h8000_0006, 1'b1, 32'h0093_ABCD, 1'b0);
        check_model();
        advance();
        drive(32'h8000_0006, 1'b1, 32'h1234_0050, 1'b1);
        check_model();
        chk1("flush_valid", instr_valid_o, !CEXT);
        chk1("flush_stall", stall_o, 1'b0);
        advance();
        drive(32'h8000_0006, 1'b0, 32'h0, 1'b0);
        check_model();
        chk("flush_idle_addr", icache_addr_o, 32'h8000_0004);
        advance();

        drive(32'h8000_0006, 1'b1, 32'h0093_ABCD, 1'b0);
        check_model();
        advance();
        drive(32'h8000_0006, 1'b0, 32'h0, 1'b0);
        check_model();
        #1 rst_n = 1'b0;
        m_split = 1'b0;
        m_lo = '0;
        #1 check_model();
        chk1("rst_split_stall", stall_o, 1'b0);
        chk("rst_split_addr", icache_addr_o, 32'h8000_0004);
        advance();
        rst_n = 1'b1;

        drive(32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
        check_model();
        chk1("ill_flag", illegal_o, CEXT);
        chk1("ill_comp", is_comp_o, CEXT);
        chk("ill_instr", instr_o, 32'h0000_0000);
        advance();

        drive(32'hFFFF_FFFE, 1'b1, 32'h00B3_1234, 1'b0);
        check_model();
        advance();
        drive(32'hFFFF_FFFE, 1'b1, 32'h0000_0000, 1'b0);
        check_model();
        chk("wrap_addr", icache_addr_o, CEXT ? 32'h0000_0000 : 32'hFFFF_FFFC);
        chk("wrap_instr", instr_o, CEXT ? 32'h0000_00B3 : 32'h0000_0000);
        advance();

        drive(32'h8000_0006, 1'b1, 32'h0093_ABCD, 1'b1);
        check_model();
        chk1("flush_entry_stall", stall_o, 1'b0);
        advance();
        drive(32'h8000_0006, 1'b0, 32'h0, 1'b0);
        check_model();
        chk("flush_entry_addr", icache_addr_o, 32'h8000_0004);
        advance();

        pc = 32'h8000_0000;
        for (int i = 0; i < 500; i++) begin
            if (!m_split) pc = $urandom & 32'hFFFF_FFFE;
            data = $urandom;
            if ($urandom_range(0, 2) == 0) data = data | 32'h0003_0003;
            drive(pc, ($urandom_range(0, 9) < 7), data, ($urandom_range(0, 19) == 0));
            check_model();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
